// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM, queues
// fetched words in a small circular FIFO and hands them to decode via valid/ready.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] ROM_START  = 64'h0,
  parameter int          ROM_SIZE   = 20*1024,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [63:0] HADDR,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  output logic        inst_fault
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  // The last 8 bytes of the ROM are excluded, matching the ROM's own decode.
  localparam logic [63:0] ROM_LIMIT = ROM_START + 64'(ROM_SIZE) - 64'd8;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [63:0]     r_fetch_pc;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic [63:0]     r_mem_pc    [FIFO_DEPTH];
  logic [31:0]     r_mem_instr [FIFO_DEPTH];
  logic            r_mem_fault [FIFO_DEPTH];

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_pc_fault;
  logic            w_unused_hi;

  assign w_valid     = (r_count != '0);
  assign w_pc_fault  = (r_fetch_pc < ROM_START) || (r_fetch_pc >= ROM_LIMIT) ||
                       (r_fetch_pc[1:0] != 2'b00);
  assign w_unused_hi = ^HRDATA[63:32];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = S_RUN;
    end else if (w_push && w_pc_fault) begin
      w_state_next = S_HALT;
    end
  end

  // Redirect masks both push and pop; pushing at full is legal alongside a pop.
  always_comb begin
    w_pop  = w_valid && inst_ready && !redirect_valid;
    w_push = (r_state == S_RUN) && !redirect_valid &&
             ((r_count < CW'(FIFO_DEPTH)) || (w_valid && inst_ready));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (!w_pc_fault) begin
          r_fetch_pc <= r_fetch_pc + 64'd4;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset: every read is qualified by a non-zero count.
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
      r_mem_instr[r_wr_ptr] <= w_pc_fault ? 32'h0 : HRDATA[31:0];
      r_mem_fault[r_wr_ptr] <= w_pc_fault;
    end
  end

  assign HADDR      = r_fetch_pc;
  assign HWDATA     = 64'h0;
  assign inst_valid = w_valid;
  assign inst_pc    = w_valid ? r_mem_pc[r_rd_ptr] : 64'h0;
  assign inst_data  = w_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
  assign inst_fault = w_valid && r_mem_fault[r_rd_ptr];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run checked
// against a program-order model of the instruction stream seen by decode.
module tb_ifetch_unit;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [63:0] ROM_LIMIT = 64'(20*1024 - 8);

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_fault;

  int n_checks = 0;
  int n_pass   = 0;

  ifetch_unit dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] rom_instr(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00000013;
      64'h4:   return 32'h00100093;
      64'h8:   return 32'h00200113;
      default: return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  assign HRDATA = {~HADDR[31:0], rom_instr(HADDR)};

  function automatic logic is_fault(input logic [63:0] a);
    return (a >= ROM_LIMIT) || (a[1:0] != 2'b00);
  endfunction

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [63:0] tgt);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = tgt;
    @(negedge HCLK);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] exp_pc;
    HRESETn = 1'b0;
    @(negedge HCLK);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", inst_valid); else n_pass++;
    n_checks++; if (inst_data !== 32'h0) $display("FAIL reset_data got %h want 0", inst_data); else n_pass++;
    n_checks++; if (inst_pc !== 64'h0) $display("FAIL reset_pc got %h want 0", inst_pc); else n_pass++;
    n_checks++; if (inst_fault !== 1'b0) $display("FAIL reset_fault got %0b want 0", inst_fault); else n_pass++;
    n_checks++; if (HADDR !== RESET_PC) $display("FAIL reset_haddr got %h want %h", HADDR, RESET_PC); else n_pass++;
    n_checks++; if (HWDATA !== 64'h0) $display("FAIL reset_hwdata got %h want 0", HWDATA); else n_pass++;
    HRESETn = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      exp_pc = RESET_PC + 64'(4*i);
      $display("reset_seq: valid=%0b pc=%h data=%h", inst_valid, inst_pc, inst_data);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== rom_instr(exp_pc) || inst_fault !== 1'b0)
        $display("FAIL reset_seq[%0d] got v=%0b pc=%h d=%h want v=1 pc=%h d=%h", i, inst_valid, inst_pc, inst_data, exp_pc, rom_instr(exp_pc));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_data !== 32'h00000013)
        $display("FAIL stall_hold[%0d] got v=%0b pc=%h d=%h want v=1 pc=0 d=00000013", i, inst_valid, inst_pc, inst_data);
      else n_pass++;
    end
    n_checks++; if (HADDR !== 64'h8) $display("FAIL stall_haddr got %h want 8", HADDR); else n_pass++;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 64'(4*i);
      $display("drain: valid=%0b pc=%h data=%h", inst_valid, inst_pc, inst_data);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== rom_instr(exp_pc))
        $display("FAIL drain[%0d] got v=%0b pc=%h d=%h want pc=%h d=%h", i, inst_valid, inst_pc, inst_data, exp_pc, rom_instr(exp_pc));
      else n_pass++;
      @(negedge HCLK);
    end
  endtask

  task automatic test_redirect();
    logic [63:0] exp_pc;
    do_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    pulse_redirect(64'h100);
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL redir_kill got valid=%0b want 0", inst_valid); else n_pass++;
    n_checks++; if (HADDR !== 64'h100) $display("FAIL redir_haddr got %h want 100", HADDR); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      exp_pc = 64'h100 + 64'(4*i);
      $display("redir_seq: valid=%0b pc=%h data=%h", inst_valid, inst_pc, inst_data);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== rom_instr(exp_pc))
        $display("FAIL redir_seq[%0d] got v=%0b pc=%h d=%h want pc=%h d=%h", i, inst_valid, inst_pc, inst_data, exp_pc, rom_instr(exp_pc));
      else n_pass++;
    end
  endtask

  task automatic test_rom_end();
    logic [63:0] exp_pc;
    pulse_redirect(ROM_LIMIT - 64'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      exp_pc = ROM_LIMIT - 64'h8 + 64'(4*i);
      $display("rom_end: valid=%0b pc=%h data=%h fault=%0b", inst_valid, inst_pc, inst_data, inst_fault);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_fault !== (i == 2) ||
          inst_data !== ((i == 2) ? 32'h0 : rom_instr(exp_pc)))
        $display("FAIL rom_end[%0d] got v=%0b pc=%h d=%h f=%0b want pc=%h f=%0b", i, inst_valid, inst_pc, inst_data, inst_fault, exp_pc, (i == 2));
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      n_checks++;
      if (inst_valid !== 1'b0 || HADDR !== ROM_LIMIT)
        $display("FAIL rom_end_halt[%0d] got v=%0b haddr=%h want v=0 haddr=%h", i, inst_valid, HADDR, ROM_LIMIT);
      else n_pass++;
    end
    pulse_redirect(64'h0);
    @(negedge HCLK);
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_data !== 32'h00000013)
      $display("FAIL rom_end_resume got v=%0b pc=%h d=%h want v=1 pc=0 d=00000013", inst_valid, inst_pc, inst_data);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    pulse_redirect(64'h102);
    inst_ready = 1'b0;
    @(negedge HCLK);
    $display("misaligned: valid=%0b pc=%h data=%h fault=%0b", inst_valid, inst_pc, inst_data, inst_fault);
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h102 || inst_fault !== 1'b1 || inst_data !== 32'h0)
      $display("FAIL misaligned got v=%0b pc=%h d=%h f=%0b want v=1 pc=102 d=0 f=1", inst_valid, inst_pc, inst_data, inst_fault);
    else n_pass++;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      n_checks++;
      if (inst_valid !== 1'b0 || HADDR !== 64'h102)
        $display("FAIL misaligned_halt[%0d] got v=%0b haddr=%h want v=0 haddr=102", i, inst_valid, HADDR);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || HADDR !== RESET_PC || inst_pc !== 64'h0)
      $display("FAIL async_reset got v=%0b haddr=%h pc=%h want v=0 haddr=%h pc=0", inst_valid, HADDR, inst_pc, RESET_PC);
    else n_pass++;
    @(negedge HCLK);
    HRESETn = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RESET_PC + 64'(4*i))
        $display("FAIL async_restart[%0d] got v=%0b pc=%h want v=1 pc=%h", i, inst_valid, inst_pc, RESET_PC + 64'(4*i));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_pc, tgt, prev_pc;
    logic [31:0] prev_data;
    logic        prev_fault, halted, stalled, just_redir, rdy, redir, efault;
    int          popped;
    do_reset();
    exp_pc = RESET_PC; halted = 0; stalled = 0; just_redir = 0; popped = 0;
    prev_pc = 0; prev_data = 0; prev_fault = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge HCLK);
      if (just_redir) begin
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rnd_redir_kill cyc=%0d got v=%0b want 0", cyc, inst_valid); else n_pass++;
      end
      if (stalled) begin
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== prev_pc || inst_data !== prev_data || inst_fault !== prev_fault)
          $display("FAIL rnd_hold cyc=%0d got pc=%h d=%h want pc=%h d=%h", cyc, inst_pc, inst_data, prev_pc, prev_data);
        else n_pass++;
      end
      if (halted) begin
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rnd_after_fault cyc=%0d got v=%0b pc=%h want v=0", cyc, inst_valid, inst_pc); else n_pass++;
      end
      rdy   = ($urandom_range(0, 3) != 0);
      redir = (!inst_valid || rdy) && ($urandom_range(0, 19) == 0);
      if (inst_valid && rdy && !redir && !halted) begin
        efault = is_fault(exp_pc);
        n_checks++;
        if (inst_pc !== exp_pc || inst_fault !== efault || inst_data !== (efault ? 32'h0 : rom_instr(exp_pc)))
          $display("FAIL rnd_entry cyc=%0d got pc=%h d=%h f=%0b want pc=%h d=%h f=%0b", cyc, inst_pc, inst_data, inst_fault,
                   exp_pc, (efault ? 32'h0 : rom_instr(exp_pc)), efault);
        else n_pass++;
        popped++;
        if (efault) halted = 1; else exp_pc = exp_pc + 64'd4;
      end
      if (redir) begin
        case ($urandom_range(0, 4))
          0: tgt = ROM_LIMIT - 64'(4 * $urandom_range(0, 6));
          1: tgt = 64'({$urandom_range(0, 32'h13FD), 2'b00});
          2: tgt = 64'({$urandom_range(0, 32'h13FD), 2'b00}) | 64'($urandom_range(1, 3));
          3: tgt = 64'h5000 + 64'(4 * $urandom_range(0, 255));
          default: tgt = 64'hFFFF_FFFF_FFFF_FFF0;
        endcase
        exp_pc = tgt; halted = 0;
      end
      stalled = inst_valid && !rdy;
      just_redir = redir;
      prev_pc = inst_pc; prev_data = inst_data; prev_fault = inst_fault;
      inst_ready = rdy; redirect_valid = redir; redirect_pc = redir ? tgt : 64'h0;
    end
    @(negedge HCLK);
    inst_ready = 1'b0; redirect_valid = 1'b0;
    $display("random: %0d entries consumed", popped);
    n_checks++; if (popped < 100) $display("FAIL rnd_progress got %0d entries want >=100", popped); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_rom_end();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
